// File: rtl/sha1_msg_feeder_pkg.sv
// Shared types and constants for the SHA-1 message feeder.
package sha1_pkg;

    localparam int unsigned BLK_WORDS = 16;

    localparam logic [159:0] SHA1_IV =
        160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [BLK_WORDS-1:0][31:0] block_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/sha1_msg_feeder_pad_word.sv
// Final-word masking: keeps the valid leading bytes and inserts the 0x80 marker.
module sha1_pad_word
    import sha1_pkg::*;
(
    input  logic [31:0] s_data,
    input  logic [2:0]  s_bytes,
    output logic [31:0] word_o,
    output logic        full_o,
    output logic [2:0]  n_bytes_o
);

    // A full final word passes through and defers the marker to the next word.
    always_comb begin
        word_o    = s_data;
        full_o    = 1'b0;
        n_bytes_o = s_bytes;
        case (s_bytes)
            3'd0: word_o = {PAD_BYTE, 24'h0};
            3'd1: word_o = {s_data[31:24], PAD_BYTE, 16'h0};
            3'd2: word_o = {s_data[31:16], PAD_BYTE, 8'h0};
            3'd3: word_o = {s_data[31:8], PAD_BYTE};
            default: begin
                word_o    = s_data;
                full_o    = 1'b1;
                n_bytes_o = 3'd4;
            end
        endcase
    end

endmodule

// File: rtl/sha1_msg_feeder.sv
// SHA-1 front end: packs a word stream into padded 512-bit blocks and
// sequences them through the compression core one block at a time.
module sha1_msg_feeder
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output block_t       data_o,
    output logic [159:0] cv_o,
    output logic         start_o,
    output logic         use_prev_cv_o,
    input  logic         out_valid_i,
    output logic         msg_done_o
);

    localparam logic [4:0] LAST_IDX   = 5'(BLK_WORDS - 1);
    localparam logic [4:0] LEN_HI_IDX = 5'(BLK_WORDS - 2);

    state_t      state;
    state_t      state_nx;
    logic [4:0]  idx;
    block_t      blk_buf;
    logic [60:0] byte_cnt;
    logic [63:0] bit_len;
    logic        pad_pending;
    logic        len_hi_done;
    logic        final_blk;
    logic        first_blk;
    logic        last_seen;
    logic        wait_first;
    logic        s_ready_q;
    logic        msg_done_q;
    logic        accept;
    logic        wait_done;
    logic [31:0] last_word;
    logic        last_full;
    logic [2:0]  last_bytes;
    logic [31:0] pad_word;

    sha1_pad_word u_pad_word (
        .s_data    (s_data),
        .s_bytes   (s_bytes),
        .word_o    (last_word),
        .full_o    (last_full),
        .n_bytes_o (last_bytes)
    );

    // Bit length is byte_cnt*8, split across the two trailing words.
    assign bit_len = {byte_cnt, 3'b000};

    assign data_o        = blk_buf;
    assign cv_o          = SHA1_IV;
    assign s_ready       = s_ready_q;
    assign msg_done_o    = msg_done_q;
    assign use_prev_cv_o = ~first_blk;

    // Padding word for the current PAD slot.
    always_comb begin
        pad_word = '0;
        if (pad_pending) begin
            pad_word = {PAD_BYTE, 24'h0};
        end else if (idx == LEN_HI_IDX) begin
            pad_word = bit_len[63:32];
        end else if (idx == LAST_IDX && len_hi_done) begin
            pad_word = bit_len[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the start pulse and handshake strobes.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        start_o   = 1'b0;
        wait_done = 1'b0;
        case (state)
            ST_FILL: begin
                accept = s_valid & s_ready_q;
                if (accept) begin
                    if (s_last) begin
                        state_nx = ST_PAD;
                    end else if (idx == LAST_IDX) begin
                        state_nx = ST_ISSUE;
                    end
                end
            end
            ST_PAD: begin
                if (idx >= LAST_IDX) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_o  = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!wait_first && out_valid_i) begin
                    wait_done = 1'b1;
                    if (final_blk) begin
                        state_nx = ST_FILL;
                    end else if (last_seen) begin
                        state_nx = ST_PAD;
                    end else begin
                        state_nx = ST_FILL;
                    end
                end
            end
            default: state_nx = ST_FILL;
        endcase
    end

    // Block buffer, length counter and message-tracking flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            blk_buf     <= '0;
            byte_cnt    <= '0;
            pad_pending <= 1'b0;
            len_hi_done <= 1'b0;
            final_blk   <= 1'b0;
            first_blk   <= 1'b1;
            last_seen   <= 1'b0;
            wait_first  <= 1'b0;
            s_ready_q   <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            s_ready_q  <= (state_nx == ST_FILL);
            msg_done_q <= wait_done & final_blk;
            wait_first <= (state == ST_ISSUE);
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        idx <= idx + 5'd1;
                        if (s_last) begin
                            blk_buf[idx[3:0]] <= last_word;
                            byte_cnt          <= byte_cnt + 61'(last_bytes);
                            pad_pending       <= last_full;
                            last_seen         <= 1'b1;
                        end else begin
                            blk_buf[idx[3:0]] <= s_data;
                            byte_cnt          <= byte_cnt + 61'd4;
                            if (idx == LAST_IDX) begin
                                final_blk <= 1'b0;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    // A final word landing in slot 15 enters PAD with idx already at 16.
                    if (!idx[4]) begin
                        blk_buf[idx[3:0]] <= pad_word;
                        idx               <= idx + 5'd1;
                        if (pad_pending) begin
                            pad_pending <= 1'b0;
                        end else if (idx == LEN_HI_IDX) begin
                            len_hi_done <= 1'b1;
                        end else if (idx == LAST_IDX && len_hi_done) begin
                            final_blk <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        idx         <= '0;
                        len_hi_done <= 1'b0;
                        final_blk   <= 1'b0;
                        first_blk   <= 1'b0;
                        if (final_blk) begin
                            first_blk <= 1'b1;
                            byte_cnt  <= '0;
                            last_seen <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_feeder.sv
// Directed bench for sha1_msg_feeder with a behavioural SHA-1 core stand-in.
module tb_sha1_msg_feeder;
    import sha1_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    block_t       data_o;
    logic [159:0] cv_o;
    logic         start_o;
    logic         use_prev_cv_o;
    logic         out_valid = 1'b0;
    logic         msg_done_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    sha1_msg_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_last        (s_last),
        .s_bytes       (s_bytes),
        .data_o        (data_o),
        .cv_o          (cv_o),
        .start_o       (start_o),
        .use_prev_cv_o (use_prev_cv_o),
        .out_valid_i   (out_valid),
        .msg_done_o    (msg_done_o)
    );

    function automatic logic [159:0] sha1_compress(input logic [159:0] cv, input block_t blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int unsigned i = 0; i < 16; i++) w[i] = blk[i];
        for (int unsigned i = 16; i < 80; i++) begin
            t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, b, c, d, e} = cv;
        for (int unsigned i = 0; i < 80; i++) begin
            if (i < 20) begin
                f = (b & c) | (~b & d); k = 32'h5A827999;
            end else if (i < 40) begin
                f = b ^ c ^ d;          k = 32'h6ED9EBA1;
            end else if (i < 60) begin
                f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
            end else begin
                f = b ^ c ^ d;          k = 32'hCA62C1D6;
            end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
    endfunction

    function automatic logic [7:0] msg_byte(input int unsigned k);
        return 8'(k * 37 + 11);
    endfunction

    // Stand-in for the compression core: fixed latency, level out_valid cleared by start.
    logic [159:0] cv_next = '0;
    logic [159:0] cv_in = '0;
    block_t       blk_in = '0;
    logic         busy = 1'b0;
    int unsigned  busy_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            busy_cnt  <= 0;
        end else if (start_o) begin
            out_valid <= 1'b0;
            busy      <= 1'b1;
            busy_cnt  <= 4;
            cv_in     <= use_prev_cv_o ? cv_next : cv_o;
            blk_in    <= data_o;
        end else if (busy) begin
            if (busy_cnt == 0) begin
                out_valid <= 1'b1;
                cv_next   <= sha1_compress(cv_in, blk_in);
                busy      <= 1'b0;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Observation log of issued blocks and completions.
    int unsigned  start_cnt = 0;
    int unsigned  done_cnt = 0;
    int unsigned  bp_err = 0;
    logic [159:0] done_dig = '0;
    block_t       blk_log[$];
    logic         up_log[$];

    always @(negedge clk) begin
        if (start_o) begin
            start_cnt++;
            blk_log.push_back(data_o);
            up_log.push_back(use_prev_cv_o);
        end
        if (msg_done_o) begin
            done_cnt++;
            done_dig = cv_next;
        end
        if (busy && s_ready) bp_err++;
    end

    block_t ref_q[$];

    task automatic build_ref(input int unsigned nbytes);
        logic [7:0] m[$];
        logic [63:0] bl;
        block_t b;
        int unsigned base;
        ref_q.delete();
        for (int unsigned k = 0; k < nbytes; k++) m.push_back(msg_byte(k));
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        bl = 64'(nbytes) * 64'd8;
        for (int unsigned j = 0; j < 8; j++) m.push_back(bl[63 - 8*j -: 8]);
        for (int unsigned n = 0; n < m.size() / 64; n++) begin
            for (int unsigned w = 0; w < 16; w++) begin
                base = 64*n + 4*w;
                b[w] = {m[base], m[base+1], m[base+2], m[base+3]};
            end
            ref_q.push_back(b);
        end
    endtask

    function automatic logic [159:0] ref_digest();
        logic [159:0] cv = SHA1_IV;
        foreach (ref_q[i]) cv = sha1_compress(cv, ref_q[i]);
        return cv;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb, output bit ok);
        int unsigned n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last; s_bytes = nb;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = s_ready;
    endtask

    task automatic send_msg(input int unsigned nbytes, output bit ok);
        int unsigned nwords;
        int unsigned lastb;
        int unsigned k;
        logic [31:0] w;
        bit okw;
        ok = 1'b1;
        nwords = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
        lastb  = nbytes - 4 * (nwords - 1);
        for (int unsigned i = 0; i < nwords; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                k = 4*i + j;
                w[31 - 8*j -: 8] = (k < nbytes) ? msg_byte(k) : 8'hAA;
            end
            send_word(w, i == nwords - 1, (i == nwords - 1) ? 3'(lastb) : 3'd4, okw);
            ok &= okw;
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_done(input int unsigned target, output bit ok);
        int unsigned n = 0;
        while (done_cnt < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
        checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL rst_start got=%b want=0", start_o); end
        checks++; if (msg_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", msg_done_o); end
        checks++; if (use_prev_cv_o !== 1'b0) begin errors++; $display("FAIL rst_use_prev got=%b want=0", use_prev_cv_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL rst_data got=%h want=0", data_o); end
        checks++; if (cv_o !== 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0) begin errors++; $display("FAIL rst_cv got=%h", cv_o); end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b want=1", s_ready); end
    endtask

    task automatic run_abc(input string tag);
        int unsigned s0, d0;
        bit ok;
        block_t exp;
        blk_log.delete(); up_log.delete();
        s0 = start_cnt; d0 = done_cnt;
        send_word(32'h61626300, 1'b1, 3'd3, ok);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL %s_accept got=timeout want=accept", tag); end
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_done_timeout got=%0d want=%0d", tag, done_cnt - d0, 1); end
        repeat (20) @(negedge clk);
        exp = '0; exp[0] = 32'h61626380; exp[15] = 32'h00000018;
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL %s_starts got=%0d want=1", tag, start_cnt - s0); end
        checks++; if (blk_log[0] !== exp) begin errors++; $display("FAIL %s_block got=%h want=%h", tag, blk_log[0], exp); end
        checks++; if (up_log[0] !== 1'b0) begin errors++; $display("FAIL %s_use_prev got=%b want=0", tag, up_log[0]); end
        checks++; if (done_dig !== 160'ha9993e364706816aba3e25717850c26c9cd0d89d) begin errors++; $display("FAIL %s_digest got=%h want=a9993e364706816aba3e25717850c26c9cd0d89d", tag, done_dig); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_count got=%0d want=1", tag, done_cnt - d0); end
    endtask

    task automatic test_abc();
        run_abc("abc");
    endtask

    task automatic test_empty();
        int unsigned d0;
        bit ok;
        block_t exp;
        blk_log.delete(); up_log.delete();
        d0 = done_cnt;
        send_word(32'hDEADBEEF, 1'b1, 3'd0, ok);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL empty_done_timeout got=%0d want=1", done_cnt - d0); end
        exp = '0; exp[0] = 32'h80000000;
        checks++; if (blk_log[0] !== exp) begin errors++; $display("FAIL empty_block got=%h want=%h", blk_log[0], exp); end
        checks++; if (done_dig !== 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709) begin errors++; $display("FAIL empty_digest got=%h want=da39a3ee5e6b4b0d3255bfef95601890afd80709", done_dig); end
    endtask

    task automatic test_55_bytes();
        int unsigned s0, d0;
        bit ok;
        blk_log.delete(); up_log.delete();
        build_ref(55);
        s0 = start_cnt; d0 = done_cnt;
        send_msg(55, ok);
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b55_done_timeout got=%0d want=1", done_cnt - d0); end
        repeat (20) @(negedge clk);
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL b55_starts got=%0d want=1", start_cnt - s0); end
        checks++; if (blk_log[0][13][7:0] !== 8'h80) begin errors++; $display("FAIL b55_w13 got=%h want=..80", blk_log[0][13]); end
        checks++; if (blk_log[0][14] !== 32'h0) begin errors++; $display("FAIL b55_w14 got=%h want=0", blk_log[0][14]); end
        checks++; if (blk_log[0][15] !== 32'h1B8) begin errors++; $display("FAIL b55_w15 got=%h want=1b8", blk_log[0][15]); end
        checks++; if (blk_log[0] !== ref_q[0]) begin errors++; $display("FAIL b55_block got=%h want=%h", blk_log[0], ref_q[0]); end
        checks++; if (done_dig !== ref_digest()) begin errors++; $display("FAIL b55_digest got=%h want=%h", done_dig, ref_digest()); end
    endtask

    task automatic test_56_bytes();
        int unsigned s0, d0;
        bit ok;
        blk_log.delete(); up_log.delete();
        build_ref(56);
        s0 = start_cnt; d0 = done_cnt;
        send_msg(56, ok);
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b56_done_timeout got=%0d want=1", done_cnt - d0); end
        repeat (30) @(negedge clk);
        checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL b56_starts got=%0d want=2", start_cnt - s0); end
        checks++; if (blk_log[0][14] !== 32'h80000000) begin errors++; $display("FAIL b56_blk1_w14 got=%h want=80000000", blk_log[0][14]); end
        checks++; if (blk_log[0][15] !== 32'h0) begin errors++; $display("FAIL b56_blk1_w15 got=%h want=0", blk_log[0][15]); end
        checks++; if (blk_log[0] !== ref_q[0]) begin errors++; $display("FAIL b56_blk1 got=%h want=%h", blk_log[0], ref_q[0]); end
        checks++; if (blk_log[1][15] !== 32'h1C0) begin errors++; $display("FAIL b56_blk2_w15 got=%h want=1c0", blk_log[1][15]); end
        checks++; if (blk_log[1] !== ref_q[1]) begin errors++; $display("FAIL b56_blk2 got=%h want=%h", blk_log[1], ref_q[1]); end
        checks++; if (up_log[0] !== 1'b0 || up_log[1] !== 1'b1) begin errors++; $display("FAIL b56_use_prev got=%b%b want=01", up_log[0], up_log[1]); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b56_done_count got=%0d want=1", done_cnt - d0); end
        checks++; if (done_dig !== ref_digest()) begin errors++; $display("FAIL b56_digest got=%h want=%h", done_dig, ref_digest()); end
    endtask

    task automatic test_back_to_back();
        int unsigned s0, d0, bp0;
        bit ok;
        blk_log.delete(); up_log.delete();
        build_ref(80);
        s0 = start_cnt; d0 = done_cnt; bp0 = bp_err;
        send_msg(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept got=timeout want=accept"); end
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got=%0d want=1", done_cnt - d0); end
        repeat (20) @(negedge clk);
        checks++; if (bp_err != bp0) begin errors++; $display("FAIL bp_ready_in_wait got=%0d want=0", bp_err - bp0); end
        checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL bp_starts got=%0d want=2", start_cnt - s0); end
        checks++; if (blk_log[0] !== ref_q[0]) begin errors++; $display("FAIL bp_blk1 got=%h want=%h", blk_log[0], ref_q[0]); end
        checks++; if (blk_log[1] !== ref_q[1]) begin errors++; $display("FAIL bp_blk2 got=%h want=%h", blk_log[1], ref_q[1]); end
        checks++; if (done_dig !== ref_digest()) begin errors++; $display("FAIL bp_digest got=%h want=%h", done_dig, ref_digest()); end
    endtask

    task automatic test_reset_in_wait();
        int unsigned s0, d0, n;
        bit ok;
        s0 = start_cnt; d0 = done_cnt;
        for (int unsigned i = 0; i < 16; i++) begin
            send_word({msg_byte(4*i), msg_byte(4*i+1), msg_byte(4*i+2), msg_byte(4*i+3)}, 1'b0, 3'd4, ok);
        end
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (start_cnt == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (start_cnt == s0) begin errors++; $display("FAIL rw_start_timeout got=0 want=1"); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (data_o !== '0 || s_ready !== 1'b0) begin errors++; $display("FAIL rw_reset_state got=%0d/%b want=0/0", data_o != '0, s_ready); end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rw_abort_done got=%0d want=0", done_cnt - d0); end
        run_abc("rw_abc");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_55_bytes();
        test_56_bytes();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
